csr_access_sequencer: RTL and testbench

- Initiator side of the machine-mode CSR register-file port.
- Takes one decoded Zicsr instruction (CSRRW/CSRRS/CSRRC and their immediate forms) from the execute stage.
- Sequences the CSR read and write transactions on the register file's mutually exclusive read/write port, computes the read-modify-write value, and returns the old CSR value for rd writeback.
- Reports illegal funct3 and illegal CSR accesses, using the register file's fault flag.

---
 rtl/csr_access_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csr_access_sequencer                                            |
// | Purpose  : Sequences Zicsr read-modify-write traffic on the CSR file port. |
// | Options  : CSR_RO_CHECK_EN - reject writes to read-only CSRs (addr 0xC00+) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module csr_access_sequencer #(
  parameter int XLEN          = 32,
  parameter int CSR_ADDR_BITS = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [CSR_ADDR_BITS-1:0] csr_addr,
  input  logic [4:0]               rs1_idx,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [4:0]               rd_idx,
  output logic                     csr_read_enable,
  output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
  input  logic                     csr_read_en_in,
  input  logic [XLEN-1:0]          csr_read_data_in,
  output logic                     csr_write_enable,
  output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
  output logic [XLEN-1:0]          csr_write_data,
  input  logic                     csr_fault_in,
  output logic                     busy,
  output logic                     rd_we,
  output logic [4:0]               rd_addr,
  output logic [XLEN-1:0]          rd_data,
  output logic                     done,
  output logic                     illegal
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

  localparam logic [1:0] c_OP_RW = 2'b01;
  localparam logic [1:0] c_OP_RS = 2'b10;

  logic [2:0]               r_state;
  logic [2:0]               w_state_next;

  logic [2:0]               r_funct3;
  logic [4:0]               r_rs1_idx;
  logic [XLEN-1:0]          r_rs1_data;

  logic                     r_csr_read_enable;
  logic [CSR_ADDR_BITS-1:0] r_csr_read_addr;
  logic                     r_csr_write_enable;
  logic [CSR_ADDR_BITS-1:0] r_csr_write_addr;
  logic [XLEN-1:0]          r_csr_write_data;
  logic                     r_busy;
  logic                     r_rd_we;
  logic [4:0]               r_rd_addr;
  logic [XLEN-1:0]          r_rd_data;
  logic                     r_done;
  logic                     r_illegal;

  logic                     w_accept;
  logic                     w_finish;
  logic                     w_finish_illegal;
  logic                     w_capture;
  logic                     w_load_wdata;
  logic [XLEN-1:0]          w_wdata_next;

  logic                     w_in_illegal;
  logic                     w_in_skip_read;
  logic                     w_in_ro_fault;
  logic [XLEN-1:0]          w_in_operand;
  logic [XLEN-1:0]          w_operand;
  logic                     w_skip_write;
  logic [XLEN-1:0]          w_rmw_value;

  logic                     w_read_en_next;
  logic                     w_write_en_next;
  logic                     w_busy_next;
  logic                     w_rd_we_next;

  // Immediate forms carry the 5-bit uimm in the rs1 field.
  assign w_in_operand   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
  assign w_in_illegal   = (funct3[1:0] == 2'b00);
  assign w_in_skip_read = (funct3[1:0] == c_OP_RW) && (rd_idx == 5'd0);

`ifdef CSR_RO_CHECK_EN
  assign w_in_ro_fault = !(funct3[1] && (rs1_idx == 5'd0))
                         && (csr_addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
`else
  assign w_in_ro_fault = 1'b0;
`endif

  assign w_operand    = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;
  assign w_skip_write = r_funct3[1] && (r_rs1_idx == 5'd0);
  assign w_accept     = (r_state == S_IDLE) && start && !sync_reset;

  always_comb begin
    w_rmw_value = w_operand;
    case (r_funct3[1:0])
      c_OP_RS: w_rmw_value = csr_read_data_in | w_operand;
      2'b11:   w_rmw_value = csr_read_data_in & ~w_operand;
      default: w_rmw_value = w_operand;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_finish         = 1'b0;
    w_finish_illegal = 1'b0;
    w_capture        = 1'b0;
    w_load_wdata     = 1'b0;
    w_wdata_next     = w_in_operand;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_in_illegal || w_in_ro_fault) begin
            w_finish         = 1'b1;
            w_finish_illegal = 1'b1;
          end else if (w_in_skip_read) begin
            w_state_next = S_WRITE;
            w_load_wdata = 1'b1;
            w_wdata_next = w_in_operand;
          end else begin
            w_state_next = S_READ;
          end
        end
      end
      S_READ: w_state_next = S_CAPTURE;
      S_CAPTURE: begin
        if (csr_fault_in || !csr_read_en_in) begin
          w_finish         = 1'b1;
          w_finish_illegal = 1'b1;
        end else begin
          w_capture = 1'b1;
          if (w_skip_write) begin
            w_finish = 1'b1;
          end else begin
            w_state_next = S_WRITE;
            w_load_wdata = 1'b1;
            w_wdata_next = w_rmw_value;
          end
        end
      end
      S_WRITE: w_state_next = S_CHECK;
      S_CHECK: begin
        w_finish         = 1'b1;
        w_finish_illegal = csr_fault_in;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_finish) begin
      w_state_next = S_IDLE;
    end
    // A synchronous abort overrides every transition and suppresses completion.
    if (sync_reset) begin
      w_state_next     = S_IDLE;
      w_finish         = 1'b0;
      w_finish_illegal = 1'b0;
      w_capture        = 1'b0;
      w_load_wdata     = 1'b0;
    end
  end

  always_comb begin
    w_read_en_next  = (w_state_next == S_READ);
    w_write_en_next = (w_state_next == S_WRITE);
    w_busy_next     = (w_state_next != S_IDLE);
    w_rd_we_next    = w_finish && !w_finish_illegal && (r_rd_addr != 5'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_funct3           <= '0;
      r_rs1_idx          <= '0;
      r_rs1_data         <= '0;
      r_csr_read_enable  <= 1'b0;
      r_csr_read_addr    <= '0;
      r_csr_write_enable <= 1'b0;
      r_csr_write_addr   <= '0;
      r_csr_write_data   <= '0;
      r_busy             <= 1'b0;
      r_rd_we            <= 1'b0;
      r_rd_addr          <= '0;
      r_rd_data          <= '0;
      r_done             <= 1'b0;
      r_illegal          <= 1'b0;
    end else begin
      r_csr_read_enable  <= w_read_en_next;
      r_csr_write_enable <= w_write_en_next;
      r_busy             <= w_busy_next;
      r_rd_we            <= w_rd_we_next;
      r_done             <= w_finish;
      r_illegal          <= w_finish_illegal;
      if (w_accept) begin
        r_funct3         <= funct3;
        r_rs1_idx        <= rs1_idx;
        r_rs1_data       <= rs1_data;
        r_csr_read_addr  <= csr_addr;
        r_csr_write_addr <= csr_addr;
        r_rd_addr        <= rd_idx;
      end
      if (w_load_wdata) begin
        r_csr_write_data <= w_wdata_next;
      end
      if (w_capture) begin
        r_rd_data <= csr_read_data_in;
      end
    end
  end

  assign csr_read_enable  = r_csr_read_enable;
  assign csr_read_addr    = r_csr_read_addr;
  assign csr_write_enable = r_csr_write_enable;
  assign csr_write_addr   = r_csr_write_addr;
  assign csr_write_data   = r_csr_write_data;
  assign busy             = r_busy;
  assign rd_we            = r_rd_we;
  assign rd_addr          = r_rd_addr;
  assign rd_data          = r_rd_data;
  assign done             = r_done;
  assign illegal          = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_csr_access_sequencer                                         |
// | Purpose  : Scoreboard bench with a CSR file model for csr_access_sequencer.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_csr_access_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_reset;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic [4:0]  rd_idx;
  logic        csr_read_enable;
  logic [11:0] csr_read_addr;
  logic        csr_read_en_in;
  logic [31:0] csr_read_data_in;
  logic        csr_write_enable;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic        csr_fault_in;
  logic        busy;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        done;
  logic        illegal;

  always #5 clk = ~clk;

  csr_access_sequencer #(.XLEN(32), .CSR_ADDR_BITS(12)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .start(start),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
    .rd_idx(rd_idx), .csr_read_enable(csr_read_enable), .csr_read_addr(csr_read_addr),
    .csr_read_en_in(csr_read_en_in), .csr_read_data_in(csr_read_data_in),
    .csr_write_enable(csr_write_enable), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data), .csr_fault_in(csr_fault_in), .busy(busy),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .illegal(illegal)
  );

  typedef struct {
    int          done_cyc;
    int          rd_cyc;
    int          wr_cyc;
    bit          ill;
    bit          we;
    logic [4:0]  rda;
    logic [31:0] rdd;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
    logic [11:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   done_total = 0;
  int   issued     = 0;
  int   rd_cnt     = 0;
  int   wr_cnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800;
      12'h341: return 32'h0000_1234;
      default: return {a, 20'h5A5A5} ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic bit unknown_csr(input logic [11:0] a);
    return a[11:8] == 4'h7;
  endfunction

  // CSR register file: registered read data and fault flag, one cycle after a strobe.
  bit          written [4096];
  logic [31:0] csr_mem [4096];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_read_en_in   <= 1'b0;
      csr_read_data_in <= 32'h0;
      csr_fault_in     <= 1'b0;
    end else begin
      csr_read_en_in   <= csr_read_enable;
      csr_read_data_in <= csr_read_enable ?
                          (written[csr_read_addr] ? csr_mem[csr_read_addr] : init_val(csr_read_addr)) : 32'h0;
      csr_fault_in     <= (csr_read_enable && unknown_csr(csr_read_addr)) ||
                          (csr_write_enable && unknown_csr(csr_write_addr));
      if (csr_write_enable && !unknown_csr(csr_write_addr)) begin
        csr_mem[csr_write_addr] <= csr_write_data;
        written[csr_write_addr] <= 1'b1;
      end
    end
  end

  // Reference CSR contents as the architectural model sees them.
  bit          ref_written [4096];
  logic [31:0] ref_mem     [4096];

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    return ref_written[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1i,
                       input logic [31:0] rs1d, input logic [4:0] rdi);
    exp_t        e;
    logic [1:0]  op;
    logic [31:0] opnd;
    logic [31:0] old;
    bit          wr;
    bit          rdx;
    bit          bad;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; csr_addr = a; rs1_idx = rs1i; rs1_data = rs1d; rd_idx = rdi;
    e    = '{default: 0};
    op   = f3[1:0];
    opnd = f3[2] ? {27'd0, rs1i} : rs1d;
    wr   = (op == 2'b01) || (rs1i != 5'd0);
    rdx  = !((op == 2'b01) && (rdi == 5'd0));
    bad  = unknown_csr(a);
    e.rda = rdi; e.addr = a; e.rd_cyc = cyc + 1;
    if (op == 2'b00) begin
      e.ill = 1'b1; e.done_cyc = cyc + 1;
    end
`ifdef CSR_RO_CHECK_EN
    else if (wr && (a[11:10] == 2'b11)) begin
      e.ill = 1'b1; e.done_cyc = cyc + 1;
    end
`endif
    else if (rdx) begin
      e.nrd = 1;
      if (bad) begin
        e.ill = 1'b1; e.done_cyc = cyc + 3;
      end else begin
        old   = ref_read(a);
        e.we  = (rdi != 5'd0);
        e.rdd = old;
        if (!wr) begin
          e.done_cyc = cyc + 3;
        end else begin
          e.nwr = 1; e.wr_cyc = cyc + 3; e.done_cyc = cyc + 5;
          case (op)
            2'b01:   e.wd = opnd;
            2'b10:   e.wd = old | opnd;
            default: e.wd = old & ~opnd;
          endcase
          ref_mem[a] = e.wd; ref_written[a] = 1'b1;
        end
      end
    end else begin
      e.nwr = 1; e.wr_cyc = cyc + 1; e.wd = opnd; e.done_cyc = cyc + 3; e.ill = bad;
      if (!bad) begin
        ref_mem[a] = opnd; ref_written[a] = 1'b1;
      end
    end
    q.push_back(e);
    issued++;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); csr_addr = 12'($urandom);
    rs1_idx = 5'($urandom); rs1_data = $urandom; rd_idx = 5'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while (q.size() > 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    chk("completion_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // Monitor: compares strobes and completions against the expected-response queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (csr_read_enable || csr_write_enable)
        chk("strobe_exclusive", 64'(csr_read_enable & csr_write_enable), 64'd0);
      if (csr_read_enable) begin
        rd_cnt++;
        if (q.size() > 0 && q[0].nrd > 0) begin
          chk("read_strobe_addr", 64'(csr_read_addr), 64'(q[0].addr));
          chk("read_strobe_cycle", 64'(cyc), 64'(q[0].rd_cyc));
        end
      end
      if (csr_write_enable) begin
        wr_cnt++;
        if (q.size() > 0 && q[0].nwr > 0) begin
          chk("write_addr", 64'(csr_write_addr), 64'(q[0].addr));
          chk("write_data", 64'(csr_write_data), 64'(q[0].wd));
          chk("write_strobe_cycle", 64'(cyc), 64'(q[0].wr_cyc));
        end
      end
      if (illegal && !done) chk("illegal_without_done", 64'(illegal), 64'd0);
      if (done) begin
        done_total++;
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          chk("illegal", 64'(illegal), 64'(mon_e.ill));
          chk("rd_we", 64'(rd_we), 64'(mon_e.we));
          if (mon_e.we) begin
            chk("rd_addr", 64'(rd_addr), 64'(mon_e.rda));
            chk("rd_data", 64'(rd_data), 64'(mon_e.rdd));
          end
          chk("read_strobe_count", 64'(rd_cnt), 64'(mon_e.nrd));
          chk("write_strobe_count", 64'(wr_cnt), 64'(mon_e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      if (sync_reset) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end else begin
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  logic [11:0] addr_list [7];

  initial begin
    addr_list[0] = 12'h300; addr_list[1] = 12'h305; addr_list[2] = 12'h341;
    addr_list[3] = 12'h7C0; addr_list[4] = 12'hF14; addr_list[5] = 12'hC00;
    addr_list[6] = 12'h340;
    reset_n = 1'b0; sync_reset = 1'b0; start = 1'b0; funct3 = 3'd0;
    csr_addr = 12'd0; rs1_idx = 5'd0; rs1_data = 32'd0; rd_idx = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", 64'({csr_read_enable, csr_write_enable}), 64'd0);
    chk("reset_flags", 64'({busy, rd_we, done, illegal}), 64'd0);
    chk("reset_addrs", 64'({csr_read_addr, csr_write_addr, rd_addr}), 64'd0);
    chk("reset_data", 64'({csr_write_data, rd_data}), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    issue(3'b010, 12'h300, 5'd5, 32'h0000_0008, 5'd10);        wait_done(); // CSRRS full RMW
    issue(3'b001, 12'h305, 5'd3, 32'h8000_0100, 5'd0);         wait_done(); // CSRRW skip_read
    issue(3'b111, 12'h341, 5'd0, 32'hFFFF_FFFF, 5'd7);         wait_done(); // CSRRCI skip_write
    issue(3'b010, 12'h7C0, 5'd3, 32'h0000_0001, 5'd4);         wait_done(); // unknown CSR
    issue(3'b001, 12'h7C0, 5'd6, 32'h0000_0055, 5'd0);         wait_done(); // unknown CSR, write side
    issue(3'b100, 12'h300, 5'd1, 32'h0000_0001, 5'd1);         wait_done(); // illegal funct3

    // start while busy must be ignored
    issue(3'b011, 12'h340, 5'd9, 32'h0000_00F0, 5'd2);
    #1 start = 1'b1; funct3 = 3'b100;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    chk("busy_start_ignored", 64'(done_total), 64'(issued));

    // synchronous abort while in WRITE
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b010; csr_addr = 12'h305; rs1_idx = 5'd9; rs1_data = $urandom; rd_idx = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 sync_reset = 1'b1;
    @(negedge clk);
    chk("abort_in_write", 64'(csr_write_enable), 64'd1);
    @(posedge clk); #1 sync_reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_strobe", 64'(csr_write_enable), 64'd0);
    repeat (6) @(posedge clk);
    ref_written[12'h305] = written[12'h305];
    ref_mem[12'h305]     = csr_mem[12'h305];

    // asynchronous reset while in READ
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b010; csr_addr = 12'h300; rs1_idx = 5'd1; rs1_data = 32'd4; rd_idx = 5'd2;
    @(posedge clk); #1 start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_strobe", 64'(csr_read_enable), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    issue(3'b001, 12'hF14, 5'd2, 32'hDEAD_BEEF, 5'd1);         wait_done(); // read-only region
    issue(3'b101, 12'h300, 5'd0, 32'h0, 5'd5);                 wait_done(); // CSRRWI uimm 0

    for (int i = 0; i < 200; i++) begin
      logic [4:0] r1;
      logic [4:0] rd;
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(3'($urandom_range(0, 7)), addr_list[$urandom_range(0, 6)], r1, $urandom, rd);
      wait_done();
    end

    repeat (5) @(posedge clk);
    chk("done_count", 64'(done_total), 64'(issued));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
